// File: rtl/cla_seq_adder_pkg.sv
// -----------------------------------------------------------------------------
// cla_seq_adder_pkg
//
// Purpose: shared definitions for the nibble-serial carry-lookahead
// add/subtract unit.
//
// Contents:
//   NIB_W     - width of one lookahead slice (one nibble)
//   OP_ADD    - i_op encoding for a + b + carry-in
//   OP_SUB    - i_op encoding for a - b
//   state_e   - controller states IDLE / RUN / DONE
//   cntWidth  - nibble counter width for a given step count (minimum 1)
// -----------------------------------------------------------------------------
package cla_seq_adder_pkg;

    localparam int NIB_W = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A single-step unit still needs a 1-bit counter so the register exists.
    function automatic int cntWidth(input int ns);
        return (ns > 1) ? $clog2(ns) : 1;
    endfunction

endpackage

// File: rtl/cla_slice_4b.sv
// -----------------------------------------------------------------------------
// cla_slice_4b
//
// Purpose: purely combinational 4-bit carry-lookahead adder slice. Every
// internal carry is expanded directly from the generate/propagate terms and
// the slice carry-in, so no carry ripples between bit positions.
//
// Ports:
//   a_i    [3:0]  in   addend nibble
//   b_i    [3:0]  in   addend nibble (already inverted by the caller for sub)
//   cin_i         in   carry into bit 0
//   s_o    [3:0]  out  sum nibble
//   cout_o        out  carry out of bit 3
// -----------------------------------------------------------------------------
module cla_slice_4b
    import cla_seq_adder_pkg::*;
(
    input  logic [NIB_W-1:0] a_i,
    input  logic [NIB_W-1:0] b_i,
    input  logic             cin_i,
    output logic [NIB_W-1:0] s_o,
    output logic             cout_o
);

    logic [NIB_W-1:0] p;
    logic [NIB_W-1:0] g;
    logic [NIB_W:0]   c;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    // Lookahead expansion: carry k is the OR of "generated at bit j and
    // propagated through every bit above j" for all j < k, plus the carry-in
    // propagated through all lower bits.
    assign c[0] = cin_i;
    assign c[1] = g[0]
                | (p[0] & c[0]);
    assign c[2] = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & c[0]);
    assign c[3] = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign s_o    = p ^ c[NIB_W-1:0];
    assign cout_o = c[NIB_W];

endmodule

// File: rtl/cla_seq_adder.sv
// -----------------------------------------------------------------------------
// cla_seq_adder
//
// Purpose: multi-cycle DW-bit add/subtract unit. One 4-bit carry-lookahead
// slice is reused once per clock, least significant nibble first, with the
// inter-nibble carry held in a register. A request is accepted in IDLE, takes
// NS cycles in RUN, and the result is presented in DONE until the consumer
// takes it. Subtraction is performed as A + ~B + 1.
//
// Parameters:
//   DW  operand/result width, multiple of 4 and at least 4
//
// Ports:
//   i_clk          in   clock, rising edge
//   i_rstn         in   asynchronous active-low reset
//   i_valid        in   request valid
//   o_ready        out  unit can accept a request (IDLE)
//   i_op           in   OP_ADD: a+b+i_c, OP_SUB: a-b (i_c ignored)
//   i_a   [DW-1:0] in   operand A
//   i_b   [DW-1:0] in   operand B
//   i_c            in   carry-in for add
//   o_valid        out  result valid (DONE)
//   i_ready        in   consumer accepts result
//   o_s   [DW-1:0] out  sum/difference
//   o_c            out  carry-out; for subtract 1 means no borrow
//   o_v            out  signed two's-complement overflow
//   o_busy         out  operation in flight or result pending
// -----------------------------------------------------------------------------
module cla_seq_adder
    import cla_seq_adder_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic          i_op,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic          i_c,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_s,
    output logic          o_c,
    output logic          o_v,
    output logic          o_busy
);

    localparam int NS = DW / NIB_W;
    localparam int CW = cntWidth(NS);
    localparam logic [CW-1:0] CNT_LAST = CW'(NS - 1);

    // Reject widths that do not split into whole nibbles.
    generate
        if (((DW % NIB_W) != 0) || (DW < NIB_W)) begin : gParamCheck
            $error("cla_seq_adder: DW must be a multiple of 4 and at least 4");
        end
    endgenerate

    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic carry_q, carry_d;
    logic ovf_q, ovf_d;

    // Operands and result are kept as nibble arrays so the counter indexes
    // the active nibble directly.
    logic [NS-1:0][NIB_W-1:0] opA_q, opA_d;
    logic [NS-1:0][NIB_W-1:0] opB_q, opB_d;
    logic [NS-1:0][NIB_W-1:0] sum_q, sum_d;

    logic [NIB_W-1:0] sliceA;
    logic [NIB_W-1:0] sliceB;
    logic [NIB_W-1:0] sliceSum;
    logic             sliceCout;

    assign sliceA = opA_q[cnt_q];
    assign sliceB = opB_q[cnt_q];

    cla_slice_4b uSlice (
        .a_i    (sliceA),
        .b_i    (sliceB),
        .cin_i  (carry_q),
        .s_o    (sliceSum),
        .cout_o (sliceCout)
    );

    // State and datapath registers. Reset clears everything, so an operation
    // interrupted by reset leaves no trace on the outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            opA_q   <= '0;
            opB_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            sum_q   <= sum_d;
        end
    end

    // Next-state and datapath update. Inputs are only sampled in IDLE, so
    // anything the requester does during RUN or DONE has no effect.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        sum_d   = sum_q;

        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    opA_d   = i_a;
                    opB_d   = (i_op == OP_SUB) ? ~i_b : i_b;
                    carry_d = (i_op == OP_SUB) ? 1'b1 : i_c;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end

            RUN: begin
                sum_d[cnt_q] = sliceSum;
                carry_d      = sliceCout;
                if (cnt_q == CNT_LAST) begin
                    // Overflow: operands (B as actually added) share a sign
                    // and the result sign differs from it.
                    ovf_d   = (opA_q[NS-1][NIB_W-1] == opB_q[NS-1][NIB_W-1])
                           && (sliceSum[NIB_W-1] != opA_q[NS-1][NIB_W-1]);
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_ready = (state_q == IDLE);
    assign o_valid = (state_q == DONE);
    assign o_busy  = (state_q == RUN) || (state_q == DONE);
    assign o_s     = sum_q;
    assign o_c     = carry_q;
    assign o_v     = ovf_q;

    // The step counter must stay inside the nibble range.
    assert property (@(posedge i_clk) disable iff (!i_rstn)
        cnt_q <= CNT_LAST);

    // A presented result must not move until it is taken.
    assert property (@(posedge i_clk) disable iff (!i_rstn)
        (o_valid && !i_ready) |=> (o_valid && $stable(o_s) && $stable(o_c) && $stable(o_v)));

endmodule
